// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, execute redirect and decode-side outputs.
// master = fetch unit, slave = surrounding pipeline / memory.
interface instr_fetch_unit_if #(
  parameter int AW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          stall;
  logic          id_ready;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [3:0]    opcode;
  logic [3:0]    rd;
  logic [3:0]    rs1;
  logic [3:0]    rs2;
  logic [15:0]   imm;
  logic [AW-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, rd, rs1, rs2, imm, instr_pc,
    input  imem_ack, imem_rdata, stall, id_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, rd, rs1, rs2, imm, instr_pc,
    output imem_ack, imem_rdata, stall, id_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, instruction register and field split.
// Optional IFU_MISALIGN_TRAP_EN: misaligned branch targets raise a sticky fetch_fault_o and park the unit.
module instr_fetch_unit #(
  parameter int              AW        = 32,
  parameter logic [AW-1:0]   RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h4000_0000
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic               fetch_fault_o,
`endif
  instr_fetch_unit_if.master bus
);

  // state   | meaning
  // S_IDLE  | one cycle after reset release; parked here after a fetch fault
  // S_FETCH | request outstanding or about to be raised for pc
  // S_VALID | instruction register holds a live word waiting for decode
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic          kill_q, kill_d;
  logic          fault_q, fault_d;

  logic          ack_w;
  logic          consume_w;
  logic          misalign_w;
  logic [AW-1:0] target_w;

  // An ack only counts against a request we actually have outstanding.
  assign ack_w     = req_q & bus.imem_ack;
  assign consume_w = bus.id_ready & ~bus.stall;

`ifdef IFU_MISALIGN_TRAP_EN
  assign misalign_w = |bus.branch_target[1:0];
  assign target_w   = bus.branch_target;
`else
  assign misalign_w = 1'b0;
  assign target_w   = bus.branch_target & ~AW'(3);
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    instr_pc_d = instr_pc_q;
    instr_d    = instr_q;
    req_d      = req_q;
    valid_d    = valid_q;
    kill_d     = kill_q;
    fault_d    = fault_q;

    if (bus.branch_taken && misalign_w) begin
      fault_d = 1'b1;
      state_d = S_IDLE;
      req_d   = 1'b0;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      kill_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.branch_taken) pc_d = target_w;
          if (!fault_q) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (!req_q) begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end
          if (ack_w) begin
            req_d = 1'b0;
            if (bus.branch_taken) begin
              pc_d   = target_w;
              kill_d = 1'b0;
            end else if (kill_q) begin
              kill_d = 1'b0;
            end else begin
              instr_d    = bus.imem_rdata;
              instr_pc_d = pc_q;
              pc_d       = pc_q + AW'(4);
              valid_d    = 1'b1;
              state_d    = S_VALID;
            end
          end else if (bus.branch_taken) begin
            // Request already on the bus keeps its address; its data is dropped on return.
            pc_d   = target_w;
            kill_d = 1'b1;
          end
        end
        S_VALID: begin
          if (bus.branch_taken) begin
            pc_d    = target_w;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = S_FETCH;
          end else if (consume_w) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_pc_q <= '0;
      instr_q    <= NOP_INSTR;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      kill_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      instr_pc_q <= instr_pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      kill_q     <= kill_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.opcode      = instr_q[31:28];
  assign bus.rd          = instr_q[27:24];
  assign bus.rs1         = instr_q[23:20];
  assign bus.rs2         = instr_q[19:16];
  assign bus.imm         = instr_q[15:0];

`ifdef IFU_MISALIGN_TRAP_EN
  assign fetch_fault_o = fault_q;
`endif

endmodule
